// File: rtl/async_fifo_rtl_pkg.sv
// Shared constants and types for the async FIFO read-side streamer.
package async_fifo_rtl_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int SKID_DEPTH     = 3;

  typedef logic [1:0] skid_ptr_t;

  // Circular pointer increment that wraps at SKID_DEPTH-1 rather than at 3.
  function automatic skid_ptr_t ptr_inc(input skid_ptr_t p);
    return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/async_fifo_rd_streamer_if.sv
// FIFO read port plus the downstream valid/ready stream, seen from the streamer.
interface async_fifo_rd_streamer_if #(
  parameter int DATA_WIDTH = async_fifo_rtl_pkg::DEF_DATA_WIDTH
);
  logic                  rinc;
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output rinc, input rempty, input rdata,
    output out_valid, input out_ready, output out_data
  );
  modport slave (
    input rinc, output rempty, output rdata,
    input out_valid, output out_ready, input out_data
  );
endinterface

// File: rtl/async_fifo_rd_streamer_skid_buf.sv
// Three-entry circular skid buffer; head entry is presented combinationally.
module rd_skid_buf
  import async_fifo_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occupancy
);
  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  skid_ptr_t             head;
  skid_ptr_t             tail;
  logic                  pop_ok;

  // Popping an empty buffer is ignored so the pointers can never desync.
  assign pop_ok    = pop && (occupancy != 2'd0);
  assign head_data = mem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ptr_inc(tail);
      end
      if (pop_ok) head <= ptr_inc(head);
      case ({push, pop_ok})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end
endmodule

// File: rtl/async_fifo_rd_streamer.sv
// Read-domain adapter: credit-limited FIFO reads into a skid buffer, out as a stream.
module async_fifo_rd_streamer
  import async_fifo_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          rclk,
  input  logic                          rrst_n,
  input  logic                          rd_enable,
  input  logic                          clr_count,
  async_fifo_rd_streamer_if.master      io,
  output logic [CNT_WIDTH-1:0]          words_out,
  output logic [1:0]                    occupancy
);
  logic                  inflight;
  logic [2:0]            credit_used;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head_data;

  // Occupancy plus the word already requested must leave room for one more.
  assign credit_used = {1'b0, occupancy} + {2'b00, inflight};
  assign io.rinc     = rrst_n && rd_enable && !io.rempty
                       && (credit_used < 3'(SKID_DEPTH));
  assign io.out_valid = (occupancy != 2'd0);
  assign io.out_data  = head_data;
  assign pop          = io.out_valid && io.out_ready;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) inflight <= 1'b0;
    else         inflight <= io.rinc;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)        words_out <= '0;
    else if (clr_count) words_out <= '0;
    else if (pop)       words_out <= words_out + 1'b1;
  end

  rd_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .push      (inflight),
    .push_data (io.rdata),
    .pop       (pop),
    .head_data (head_data),
    .occupancy (occupancy)
  );
endmodule

// File: tb/tb_async_fifo_rd_streamer.sv
// Bench for async_fifo_rd_streamer: FIFO source model, outstanding-word scoreboard.
module tb_async_fifo_rd_streamer;
  logic        rclk;
  logic        rrst_n;
  logic        rd_enable;
  logic        clr_count;
  logic [15:0] words_out;
  logic [1:0]  occupancy;

  async_fifo_rd_streamer_if #(.DATA_WIDTH(8)) bus ();

  async_fifo_rd_streamer #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rd_enable (rd_enable),
    .clr_count (clr_count),
    .io        (bus),
    .words_out (words_out),
    .occupancy (occupancy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // Model: words still in the FIFO, and words taken from it but not yet delivered.
  logic [7:0]  fifo_q[$];
  logic [7:0]  pend[$];
  bit          inflight_m;
  logic [15:0] wo_m;
  bit          force_empty;

  logic        s_rinc, s_valid, s_fire;
  logic [7:0]  s_data;
  logic [1:0]  s_occ;
  logic [15:0] s_wo;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic upd_empty();
    bus.rempty = force_empty || (fifo_q.size() == 0);
  endtask

  task automatic model_reset();
    pend.delete();
    inflight_m = 1'b0;
    wo_m       = '0;
  endtask

  task automatic step();
    bit         e_rinc, e_valid, took, fire;
    int         e_occ;
    logic [7:0] w;
    w = 8'h00;
    @(negedge rclk);
    e_rinc  = rrst_n && rd_enable && !bus.rempty && (pend.size() < 3);
    e_occ   = pend.size() - int'(inflight_m);
    e_valid = (e_occ != 0);
    s_rinc = bus.rinc; s_valid = bus.out_valid; s_data = bus.out_data;
    s_occ = occupancy; s_wo = words_out;
    chk("rinc", int'(s_rinc), int'(e_rinc));
    chk("occupancy", int'(s_occ), e_occ);
    chk("out_valid", int'(s_valid), int'(e_valid));
    if (e_valid) chk("out_data", int'(s_data), int'(pend[0]));
    chk("words_out", int'(s_wo), int'(wo_m));
    fire   = e_valid && bus.out_ready;
    took   = e_rinc;
    s_fire = fire;
    @(posedge rclk);
    if (rrst_n) begin
      if (clr_count) wo_m = '0;
      else if (fire) wo_m = wo_m + 16'd1;
      if (fire) void'(pend.pop_front());
      if (took) begin
        w = fifo_q.pop_front();
        pend.push_back(w);
      end
      inflight_m = took;
    end
    #1;
    if (took) bus.rdata = w;
    upd_empty();
  endtask

  task automatic drain();
    int n;
    n = 0;
    force_empty = 1'b0; upd_empty();
    rd_enable = 1'b1; bus.out_ready = 1'b1;
    while ((fifo_q.size() != 0 || pend.size() != 0) && n < 200) begin
      step(); n++;
    end
    chk("drain_done", int'(fifo_q.size() + pend.size()), 0);
  endtask

  typedef struct {
    bit         rd_en;
    bit         ready;
    bit         e_rinc;
    bit         e_valid;
    logic [7:0] e_data;
    logic [1:0] e_occ;
    logic [15:0] e_wo;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   n_rinc, delivered, gaps, max_occ, nf, n;
    logic [7:0] first;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1, 16'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 2'd1, 16'd1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 2'd1, 16'd2};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 16'd3};

    rrst_n = 1'b0; rd_enable = 1'b0; clr_count = 1'b0; force_empty = 1'b0;
    bus.out_ready = 1'b0; bus.rdata = 8'h00; bus.rempty = 1'b1;
    model_reset();
    #3;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_words_out", int'(words_out), 0);

    // Preloaded FIFO and enabled read while in reset: no strobe may escape.
    fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
    rd_enable = 1'b1; bus.out_ready = 1'b1; upd_empty();
    repeat (3) step();
    rrst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      rd_enable = tbl[i].rd_en; bus.out_ready = tbl[i].ready;
      step();
      chk("tbl_rinc", int'(s_rinc), int'(tbl[i].e_rinc));
      chk("tbl_valid", int'(s_valid), int'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk("tbl_data", int'(s_data), int'(tbl[i].e_data));
      chk("tbl_occ", int'(s_occ), int'(tbl[i].e_occ));
      chk("tbl_words", int'(s_wo), int'(tbl[i].e_wo));
    end

    // Backpressure: exactly three reads, first word held.
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'h40 + 8'(i));
    rd_enable = 1'b1; bus.out_ready = 1'b0; upd_empty();
    n_rinc = 0; nf = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_rinc += int'(s_rinc);
      if (s_valid && s_data != 8'h40) nf++;
    end
    chk("bp_rinc_pulses", n_rinc, 3);
    chk("bp_occ", int'(s_occ), 3);
    chk("bp_hold_changes", nf, 0);
    bus.out_ready = 1'b1;
    delivered = 0; gaps = 0; n = 0;
    while (delivered < 16 && n < 60) begin
      step(); n++;
      if (s_fire) delivered++;
      else if (delivered > 0) gaps++;
    end
    chk("bp_delivered", delivered, 16);
    chk("bp_gaps", gaps, 0);

    // Toggled ready after a count clear.
    clr_count = 1'b1; bus.out_ready = 1'b0; step(); clr_count = 1'b0;
    for (int i = 0; i < 16; i++) fifo_q.push_back(8'h80 + 8'(i));
    upd_empty();
    delivered = 0; max_occ = 0; n = 0;
    while (delivered < 16 && n < 100) begin
      bus.out_ready = (n % 2 == 0);
      step(); n++;
      if (s_fire) delivered++;
      if (int'(s_occ) > max_occ) max_occ = int'(s_occ);
    end
    chk("tog_delivered", delivered, 16);
    chk("tog_max_occ_le3", int'(max_occ <= 3), 1);
    chk("tog_words_out", int'(words_out), 16);

    // Empty flag rises right after a committed read.
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'hA0 + 8'(i));
    rd_enable = 1'b1; bus.out_ready = 1'b1; upd_empty();
    step();
    chk("emp_first_rinc", int'(s_rinc), 1);
    force_empty = 1'b1; upd_empty();
    n_rinc = 0; delivered = 0; first = 8'h00;
    for (int i = 0; i < 6; i++) begin
      step();
      n_rinc += int'(s_rinc);
      if (s_fire) begin delivered++; first = s_data; end
    end
    chk("emp_rinc_while_empty", n_rinc, 0);
    chk("emp_delivered", delivered, 1);
    chk("emp_word", int'(first), 8'hA0);
    drain();

    // Enable dropped with two words buffered.
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'hC0 + 8'(i));
    rd_enable = 1'b1; bus.out_ready = 1'b0; upd_empty();
    step(); step(); rd_enable = 1'b0; step();
    chk("dis_occ_two", int'(occupancy), 2);
    bus.out_ready = 1'b1; n_rinc = 0; delivered = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_rinc += int'(s_rinc);
      if (s_fire) delivered++;
    end
    chk("dis_rinc", n_rinc, 0);
    chk("dis_delivered", delivered, 2);
    drain();

    // Asynchronous reset with two words buffered.
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h70 + 8'(i));
    rd_enable = 1'b1; bus.out_ready = 1'b0; upd_empty();
    step(); step(); rd_enable = 1'b0; step();
    rd_enable = 1'b1; bus.out_ready = 1'b1;
    #2 rrst_n = 1'b0;
    #1;
    chk("ar_out_valid", int'(bus.out_valid), 0);
    chk("ar_occupancy", int'(occupancy), 0);
    chk("ar_words_out", int'(words_out), 0);
    chk("ar_rinc", int'(bus.rinc), 0);
    model_reset();
    step(); step();
    rrst_n = 1'b1;
    n = 0; s_fire = 1'b0;
    while (!s_fire && n < 10) begin step(); n++; end
    chk("ar_resume_fire", int'(s_fire), 1);
    chk("ar_resume_word", int'(s_data), 8'h72);
    drain();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rd_enable     = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      clr_count     = ($urandom % 32) == 0;
      force_empty   = ($urandom % 8) == 0;
      if (($urandom % 2) == 0) fifo_q.push_back(8'($urandom));
      upd_empty();
      step();
    end
    clr_count = 1'b0;
    drain();

    // Counter wrap.
    clr_count = 1'b1; bus.out_ready = 1'b0; rd_enable = 1'b0; step(); clr_count = 1'b0;
    for (int i = 0; i < 65540; i++) fifo_q.push_back(8'(i));
    rd_enable = 1'b1; bus.out_ready = 1'b1; upd_empty();
    n = 0;
    while (wo_m != 16'hFFFE && n < 70000) begin step(); n++; end
    chk("wrap_reach_fffe", int'(wo_m), 16'hFFFE);
    chk("wrap_at_fffe", int'(words_out), 16'hFFFE);
    nf = 0;
    for (int i = 0; i < 3; i++) begin step(); nf += int'(s_fire); end
    chk("wrap_pops", nf, 3);
    chk("wrap_to_0001", int'(words_out), 16'h0001);
    clr_count = 1'b1; step(); clr_count = 1'b0;
    chk("clr_with_pop_fire", int'(s_fire), 1);
    chk("clr_with_pop", int'(words_out), 0);
    rd_enable = 1'b0; fifo_q.delete(); upd_empty();
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
